// File: rtl/seq_shift_unit.sv
// ----------------------------------------------------------------------------
// seq_shift_unit: iterative SLL/SRL/SRA unit, up to STEP bits per cycle,
// valid/ready request and response channels.      Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic [1:0]         req_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
  localparam logic [1:0]         OP_SLL = 2'b00;
  localparam logic [1:0]         OP_SRL = 2'b01;

  state_e             state_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   resp_q;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [SHAMT_W-1:0] step_k;
  logic [1:0]         op_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic               busy_q;

  // Only shifts of 0..STEP are ever needed, so select among constant shifts
  // instead of building a full barrel shifter.
  always_comb begin
    step_k = (count_q <= STEP_C) ? count_q : STEP_C;
    data_d = data_q;
    for (int j = 1; j <= STEP; j++) begin
      if (step_k == SHAMT_W'(j)) begin
        if (op_q == OP_SLL) begin
          data_d = data_q << j;
        end else if (op_q == OP_SRL) begin
          data_d = data_q >> j;
        end else begin
          data_d = $unsigned($signed(data_q) >>> j);
        end
      end
    end
    count_d = count_q - step_k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      resp_q       <= '0;
      count_q      <= '0;
      op_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            data_q      <= req_data;
            count_q     <= req_shamt;
            op_q        <= req_op;
            state_q     <= S_SHIFT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_SHIFT: begin
          data_q  <= data_d;
          count_q <= count_d;
          // Result is captured separately so resp_data never shows partial shifts.
          if (count_q <= STEP_C) begin
            state_q      <= S_DONE;
            resp_q       <= data_d;
            resp_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_shift_unit: directed bench for seq_shift_unit, STEP=1 and STEP=4.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_shift_unit;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      vld, rrdy;
  logic [1:0][31:0] din;
  logic [1:0][4:0] sh;
  logic [1:0][1:0] op;

  logic        s1_rdy, s1_rv, s1_bsy, s4_rdy, s4_rv, s4_bsy;
  logic [31:0] s1_rd, s4_rd;
  logic [1:0]       rdy, rv, bsy;
  logic [1:0][31:0] rd;
  assign rdy = {s4_rdy, s1_rdy};
  assign rv  = {s4_rv, s1_rv};
  assign bsy = {s4_bsy, s1_bsy};
  assign rd  = {s4_rd, s1_rd};

  int errs   = 0;
  int checks = 0;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(s1_rdy),
    .req_data(din[0]), .req_shamt(sh[0]), .req_op(op[0]),
    .resp_valid(s1_rv), .resp_ready(rrdy[0]), .resp_data(s1_rd), .busy(s1_bsy)
  );

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(s4_rdy),
    .req_data(din[1]), .req_shamt(sh[1]), .req_op(op[1]),
    .resp_valid(s4_rv), .resp_ready(rrdy[1]), .resp_data(s4_rd), .busy(s4_bsy)
  );

  function automatic int step_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    if (o == SLL) return d << s;
    if (o == SRL) return d >> s;
    return sd >>> s;
  endfunction

  function automatic int ref_lat(int s, int st);
    int l;
    l = (s + st - 1) / st;
    return (l < 1) ? 1 : l;
  endfunction

  // Transaction-level model: phase 0 idle, 1 computing, 2 result offered.
  int          ph[2];
  int          rem[2];
  logic [31:0] mres[2];
  logic [31:0] mlast[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ph[i]    <= 0;
        rem[i]   <= 0;
        mres[i]  <= '0;
        mlast[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (vld[i]) begin
            mres[i] <= ref_shift(din[i], sh[i], op[i]);
            rem[i]  <= ref_lat(int'(sh[i]), step_of(i));
            ph[i]   <= 1;
          end
          1: if (rem[i] == 1) begin
            ph[i]    <= 2;
            mlast[i] <= mres[i];
          end else begin
            rem[i] <= rem[i] - 1;
          end
          default: if (rrdy[i]) ph[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(int i, logic [31:0] d, logic [4:0] s, logic [1:0] o, string nm);
    int n;
    din[i] = d; sh[i] = s; op[i] = o; vld[i] = 1'b1;
    n = 0;
    while (!rdy[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept"}, 32'(rdy[i]), 32'd1);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_resp(int i, int explat, string nm);
    int k;
    k = 0;
    while (!rv[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 32'(k), 32'(explat));
  endtask

  task automatic run_lit(int i, logic [31:0] d, logic [4:0] s, logic [1:0] o,
                         logic [31:0] exp, int explat, string nm);
    issue(i, d, s, o, nm);
    wait_resp(i, explat, nm);
    chk({nm, "_data"}, rd[i], exp);
    rrdy[i] = 1'b1;
    @(negedge clk);
    rrdy[i] = 1'b0;
  endtask

  task automatic b2b(int i, int nops);
    logic [31:0] q[$];
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    int loaded, got, cyc;
    loaded = 0; got = 0; cyc = 0;
    rrdy[i] = 1'b1;
    while ((loaded < nops || got < nops) && cyc < nops * 40) begin
      if (rv[i]) begin
        if (q.size() == 0) chk("b2b_extra_resp", rd[i], 32'hxxxx_xxxx);
        else chk($sformatf("b2b%0d_data_%0d", i, got), rd[i], q.pop_front());
        got++;
      end
      if (rdy[i]) begin
        if (loaded < nops) begin
          d = $urandom; s = 5'($urandom_range(0, 31)); o = 2'($urandom_range(0, 3));
          din[i] = d; sh[i] = s; op[i] = o; vld[i] = 1'b1;
          q.push_back(ref_shift(d, s, o));
          loaded++;
        end else begin
          vld[i] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    vld[i] = 1'b0;
    rrdy[i] = 1'b0;
    chk($sformatf("b2b%0d_count", i), 32'(got), 32'(nops));
    chk($sformatf("b2b%0d_left", i), 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = '0; rrdy = '0; din = '0; sh = '0; op = '0;
    // Per-cycle comparison of both units against the model.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_req_ready", i), 32'(rdy[i]), 32'(ph[i] == 0));
            chk($sformatf("u%0d_resp_valid", i), 32'(rv[i]), 32'(ph[i] == 2));
            chk($sformatf("u%0d_busy", i), 32'(bsy[i]), 32'(ph[i] != 0));
            chk($sformatf("u%0d_resp_data", i), rd[i], mlast[i]);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(rdy[i]), 32'd1);
      chk("rst_resp_valid", 32'(rv[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_resp_data", rd[i], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 32; s++) begin
      run_lit(0, 32'hFFFF_FFFF, 5'(s), SLL, 32'hFFFF_FFFF << s, (s == 0) ? 1 : s, "sweep_sll");
      run_lit(0, 32'hFFFF_FFFF, 5'(s), SRL, 32'hFFFF_FFFF >> s, (s == 0) ? 1 : s, "sweep_srl");
    end

    run_lit(0, 32'h8000_0000, 5'd31, SRA,   32'hFFFF_FFFF, 31, "sra_min_31");
    run_lit(0, 32'h7FFF_FFFF, 5'd4,  2'b11, 32'h07FF_FFFF, 4,  "sra_pos_4");
    run_lit(0, 32'h8000_0000, 5'd31, SRL,   32'h0000_0001, 31, "srl_msb_31");
    run_lit(1, 32'h0000_0001, 5'd31, SLL,   32'h8000_0000, 8,  "s4_sll_31");
    run_lit(1, 32'hDEAD_BEEF, 5'd0,  SRA,   32'hDEAD_BEEF, 1,  "s4_shamt0");
    run_lit(1, 32'hF000_0000, 5'd6,  SRA,   32'hFFC0_0000, 2,  "s4_sra_6");
    run_lit(1, 32'h1234_5678, 5'd5,  SRL,   32'h0091_A2B3, 2,  "s4_srl_5");

    issue(0, 32'h1234_5678, 5'd8, SRL, "bp");
    wait_resp(0, 8, "bp");
    din[0] = 32'hAAAA_5555; sh[0] = 5'd1; op[0] = SLL; vld[0] = 1'b1;
    repeat (10) begin
      chk("bp_valid", 32'(rv[0]), 32'd1);
      chk("bp_data", rd[0], 32'h0012_3456);
      chk("bp_req_ready", 32'(rdy[0]), 32'd0);
      @(negedge clk);
    end
    vld[0] = 1'b0; rrdy[0] = 1'b1;
    @(negedge clk);
    rrdy[0] = 1'b0;
    chk("bp_after_valid", 32'(rv[0]), 32'd0);
    chk("bp_after_data", rd[0], 32'h0012_3456);
    chk("bp_after_ready", 32'(rdy[0]), 32'd1);

    issue(0, 32'h0000_0001, 5'd20, SLL, "abort");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_req_ready", 32'(rdy[0]), 32'd1);
    chk("abort_resp_valid", 32'(rv[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_resp_data", rd[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_lit(0, 32'h0000_0001, 5'd3, SLL, 32'h0000_0008, 3, "after_abort");

    b2b(0, 100);
    b2b(1, 100);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
